// File: rtl/req_gnt_responder.sv
// req_gnt_responder: request/grant responder with a clamped busy phase, a one-deep pending request and a grant counter; REQ_GNT_ASSERT_EN compiles in protocol assertions
module req_gnt_responder #(
    parameter int MAX_BUSY = 5,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [2:0]       busy_len,
    output logic             busy,
    output logic             gnt,
    output logic             pending,
    output logic [CNT_W-1:0] grant_cnt
);
    typedef enum logic [1:0] {IDLE, BUSY, GNT} state_t;
    state_t     state, state_n;
    logic [2:0] cnt, cnt_n, lat;
    logic       pending_n;

    assign lat = busy_len == 3'd0 ? 3'd1 : busy_len > 3'(MAX_BUSY) ? 3'(MAX_BUSY) : busy_len;

    // next state, busy down-counter and one-deep pending request
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pending_n = pending;
        case (state)
            IDLE: if (req || pending) begin
                state_n   = BUSY;
                cnt_n     = lat - 3'd1;
                pending_n = 1'b0;
            end
            BUSY: begin
                pending_n = pending | req;
                state_n   = cnt == 3'd0 ? GNT : BUSY;
                cnt_n     = cnt == 3'd0 ? cnt : cnt - 3'd1;
            end
            GNT: begin
                pending_n = req;
                state_n   = pending ? BUSY : IDLE;
                cnt_n     = pending ? lat - 3'd1 : cnt;
            end
            default: state_n = IDLE;
        endcase
    end

    // state register with registered busy/gnt decodes and grant counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            pending   <= 1'b0;
            busy      <= 1'b0;
            gnt       <= 1'b0;
            grant_cnt <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pending   <= pending_n;
            busy      <= state_n == BUSY;
            gnt       <= state_n == GNT;
            grant_cnt <= grant_cnt + CNT_W'(state == GNT);
        end
    end

`ifdef REQ_GNT_ASSERT_EN
    for (genvar k = 1; k <= MAX_BUSY; k++) begin : g_len
        a_txn: assert property (@(posedge clk) disable iff (rst)
            (state != BUSY && state_n == BUSY && lat == 3'(k)) |=> busy [*k] ##1 gnt);
    end
    a_excl: assert property (@(posedge clk) disable iff (rst) !(busy && gnt));
    a_gnt:  assert property (@(posedge clk) disable iff (rst) gnt |=> (!gnt || busy));
`endif
endmodule

// File: doc/req_gnt_responder.md
REQ_GNT_RESPONDER -- requirements
Module: req_gnt_responder

Interface
REQ-001 Parameter MAX_BUSY, default 5, shall set the largest busy-phase length in cycles (legal 1..7).
REQ-002 Parameter CNT_W, default 8, shall set the width of the grant counter.
REQ-003 clk  input  1  shall be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  shall be the synchronous, active-high reset, sampled on posedge clk.
REQ-005 req  input  1  shall be the request from the initiator, sampled on posedge clk.
REQ-006 busy_len  input  3  shall set the busy-phase length, sampled only when a request is accepted.
REQ-007 busy  output  1  shall be high while the responder is in its busy phase.
REQ-008 gnt  output  1  shall be a one-cycle grant pulse ending each transaction.
REQ-009 pending  output  1  shall be high while a second request is held for service.
REQ-010 grant_cnt  output  CNT_W  shall count completed grants.

Function
REQ-011 The FSM shall have exactly three states: IDLE, BUSY, GNT; busy is high only in BUSY, and gnt is high only in GNT, both registered.
REQ-012 In IDLE, req=1 at edge N shall move the FSM to BUSY at edge N+1, so that req ##1 busy[*L] ##1 gnt holds.
REQ-013 L shall be latched at acceptance: busy_len=0 yields L=1; busy_len>MAX_BUSY yields L=MAX_BUSY; otherwise L=busy_len.
REQ-014 BUSY shall last exactly L consecutive cycles, with a down-counter loaded with L-1 and GNT entered when the counter is 0.
REQ-015 GNT shall last exactly one cycle.
REQ-016 At the GNT exit, the FSM shall return to IDLE, or go directly to BUSY with a freshly latched L if pending=1.
REQ-017 req=1 sampled in BUSY or GNT shall set pending (one-deep); further requests while pending=1 shall be dropped.
REQ-018 pending shall clear on the cycle the held request enters BUSY; in GNT, a simultaneous set and clear shall leave pending=1.
REQ-019 For a held request, busy_len shall be sampled at the GNT-exit edge, not at the edge where req was seen.
REQ-020 grant_cnt shall increment by 1 on every GNT cycle and wrap from 2^CNT_W-1 to 0 without a flag.
REQ-021 req held high continuously shall produce back-to-back transactions with no IDLE cycle between a GNT and the next BUSY.
REQ-022 busy and gnt shall never be high together.

Reset
REQ-023 rst=1 at any edge shall force the FSM to IDLE and clear busy, gnt, pending, grant_cnt and the busy counter to 0 on the next cycle.
REQ-024 A transaction interrupted by reset shall not produce gnt, and a pending request at reset shall be discarded.
REQ-025 req sampled in the same cycle as rst=1 shall be ignored.

Configuration
REQ-026 Macro REQ_GNT_ASSERT_EN defined: the block shall compile in concurrent assertions, disabled while rst=1, for the checks below.
REQ-027 Assertion (a): accepted req ##1 busy[*L] ##1 gnt, for the latched L.
REQ-028 Assertion (b): !(busy && gnt).
REQ-029 Assertion (c): gnt is followed by !gnt, or by busy on the next cycle.
REQ-030 Macro REQ_GNT_ASSERT_EN undefined: no assertion code shall be compiled, and ports and function shall be identical.

Verification
REQ-031 Scenario: reset, then req=1 for one cycle with busy_len=2 -> busy high 2 cycles starting the next cycle, then gnt 1 cycle, grant_cnt=1.
REQ-032 Scenario: busy_len=0 and then busy_len=6 (MAX_BUSY=5), one req each -> busy lasts 1 cycle, then 5 cycles.
REQ-033 Scenario: req pulse in the 2nd busy cycle of an L=3 transaction with busy_len changed to 4 before GNT -> pending=1; after gnt, busy runs 4 cycles with no idle gap; pending clears on the first of those busy cycles.
REQ-034 Scenario: req held high for 20 cycles, busy_len=1 -> repeating busy,gnt pairs with no idle cycle, and grant_cnt matches the gnt count.
REQ-035 Scenario: rst asserted in the 3rd busy cycle of an L=5 transaction with pending=1 -> next cycle all outputs 0, no gnt follows, and the FSM is in IDLE.
REQ-036 Scenario: CNT_W=2, 5 transactions -> grant_cnt sequence 1,2,3,0,1; run with REQ_GNT_ASSERT_EN defined and no assertion failures.
